dual_core_mem_arbiter: RTL and testbench

- Arbitrates two CPU cores' load/store requests onto one single-ported shared data memory.
- Serves one transaction at a time with round-robin priority.
- Sits between the core pair and the shared memory in the multicore CPU, in the sys_clk domain.
- Also keeps per-core saturating transaction counters for debug readout.

---
 rtl/dual_core_mem_arbiter_if.sv | 38 +++
 rtl/dual_core_mem_arbiter.sv | 114 +++++++++++
 tb/tb_dual_core_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_core_mem_arbiter_if.sv
// Bundle between the two cores, the arbiter and the shared single-ported data memory.
// master = core pair plus memory side, slave = arbiter.
interface dual_core_mem_arbiter_if #(
  parameter int DATA_SIZE = 32,
  parameter int MEM_SIZE  = 8,
  parameter int CNT_W     = 16
);
  logic                 req0;
  logic                 req1;
  logic                 we0;
  logic                 we1;
  logic [MEM_SIZE-1:0]  adrs0;
  logic [MEM_SIZE-1:0]  adrs1;
  logic [DATA_SIZE-1:0] wdata0;
  logic [DATA_SIZE-1:0] wdata1;
  logic                 ack0;
  logic                 ack1;
  logic [DATA_SIZE-1:0] rdata0;
  logic [DATA_SIZE-1:0] rdata1;
  logic                 mem_en;
  logic                 mem_we;
  logic [MEM_SIZE-1:0]  mem_adrs;
  logic [DATA_SIZE-1:0] mem_wdata;
  logic [DATA_SIZE-1:0] mem_rdata;
  logic                 busy;
  logic [CNT_W-1:0]     cnt0;
  logic [CNT_W-1:0]     cnt1;

  modport master (
    output req0, req1, we0, we1, adrs0, adrs1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, mem_en, mem_we, mem_adrs, mem_wdata, busy, cnt0, cnt1
  );

  modport slave (
    input  req0, req1, we0, we1, adrs0, adrs1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, mem_en, mem_we, mem_adrs, mem_wdata, busy, cnt0, cnt1
  );
endinterface

// File: rtl/dual_core_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-ported data memory between two cores.
// One transaction at a time, 4 cycles each including IDLE; saturating per-core completion counters.
module dual_core_mem_arbiter #(
  parameter int DATA_SIZE = 32,
  parameter int MEM_SIZE  = 8,
  parameter int CNT_W     = 16
) (
  input logic                    sys_clk_i,
  input logic                    resetn_i,
  dual_core_mem_arbiter_if.slave arb_bus
);
  // state | meaning
  // IDLE  | no transaction; request granted and latched on exit
  // ISSUE | mem_en strobe with latched access
  // WAIT  | synchronous read data returns, captured for loads
  // RESP  | ack pulse to the selected core
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e               state_q;
  logic                 sel_q;
  logic                 last_q;
  logic                 we_q;
  logic [MEM_SIZE-1:0]  adrs_q;
  logic [DATA_SIZE-1:0] wdata_q;
  logic                 mem_en_q;
  logic                 busy_q;
  logic                 ack0_q;
  logic                 ack1_q;
  logic [DATA_SIZE-1:0] rdata0_q;
  logic [DATA_SIZE-1:0] rdata1_q;
  logic [CNT_W-1:0]     cnt0_q;
  logic [CNT_W-1:0]     cnt1_q;

  logic gnt_any_d;
  logic gnt_sel_d;

  // On a tie the core that was not served last wins.
  always_comb begin
    gnt_any_d = arb_bus.req0 | arb_bus.req1;
    if (arb_bus.req0 && arb_bus.req1) gnt_sel_d = ~last_q;
    else                              gnt_sel_d = arb_bus.req1;
  end

  always_ff @(posedge sys_clk_i) begin
    if (!resetn_i) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      adrs_q   <= '0;
      wdata_q  <= '0;
      mem_en_q <= 1'b0;
      busy_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      mem_en_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_any_d) begin
            sel_q    <= gnt_sel_d;
            we_q     <= gnt_sel_d ? arb_bus.we1    : arb_bus.we0;
            adrs_q   <= gnt_sel_d ? arb_bus.adrs1  : arb_bus.adrs0;
            wdata_q  <= gnt_sel_d ? arb_bus.wdata1 : arb_bus.wdata0;
            mem_en_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          // ack, load data and count are registered together so they appear in RESP.
          if (sel_q) begin
            ack1_q <= 1'b1;
            if (!we_q) rdata1_q <= arb_bus.mem_rdata;
            if (cnt1_q != CNT_MAX) cnt1_q <= cnt1_q + CNT_ONE;
          end else begin
            ack0_q <= 1'b1;
            if (!we_q) rdata0_q <= arb_bus.mem_rdata;
            if (cnt0_q != CNT_MAX) cnt0_q <= cnt0_q + CNT_ONE;
          end
          last_q  <= sel_q;
          state_q <= RESP;
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arb_bus.ack0      = ack0_q;
  assign arb_bus.ack1      = ack1_q;
  assign arb_bus.rdata0    = rdata0_q;
  assign arb_bus.rdata1    = rdata1_q;
  assign arb_bus.mem_en    = mem_en_q;
  assign arb_bus.mem_we    = we_q;
  assign arb_bus.mem_adrs  = adrs_q;
  assign arb_bus.mem_wdata = wdata_q;
  assign arb_bus.busy      = busy_q;
  assign arb_bus.cnt0      = cnt0_q;
  assign arb_bus.cnt1      = cnt1_q;
endmodule

// File: tb/tb_dual_core_mem_arbiter.sv
// Bench for dual_core_mem_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-timing reference model; a CNT_W=2 instance covers counter saturation.
`timescale 1ns/1ps
module tb_dual_core_mem_arbiter;
  localparam int DW   = 32;
  localparam int AW   = 8;
  localparam int CW   = 16;
  localparam int CW_S = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic sys_clk = 1'b0;
  logic resetn  = 1'b0;
  always #5 sys_clk = ~sys_clk;

  dual_core_mem_arbiter_if #(.DATA_SIZE(DW), .MEM_SIZE(AW), .CNT_W(CW))   bus();
  dual_core_mem_arbiter_if #(.DATA_SIZE(DW), .MEM_SIZE(AW), .CNT_W(CW_S)) bus_s();

  dual_core_mem_arbiter #(.DATA_SIZE(DW), .MEM_SIZE(AW), .CNT_W(CW)) dut (
    .sys_clk_i (sys_clk),
    .resetn_i  (resetn),
    .arb_bus   (bus)
  );

  dual_core_mem_arbiter #(.DATA_SIZE(DW), .MEM_SIZE(AW), .CNT_W(CW_S)) dut_s (
    .sys_clk_i (sys_clk),
    .resetn_i  (resetn),
    .arb_bus   (bus_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return {16'hC0DE, a, ~a};
  endfunction

  // Synchronous single-port memory behind the main instance.
  logic [DW-1:0] ram [256];
  bit            ram_v [256];
  logic [DW-1:0] ram_rdata;
  always @(posedge sys_clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_adrs]   <= bus.mem_wdata;
        ram_v[bus.mem_adrs] <= 1'b1;
      end else begin
        ram_rdata <= ram_v[bus.mem_adrs] ? ram[bus.mem_adrs] : dflt(bus.mem_adrs);
      end
    end
  end
  assign bus.mem_rdata   = ram_rdata;
  assign bus_s.mem_rdata = '0;

  // Reference model: a granted transaction latched at edge t0 strobes memory in cycle t0+1,
  // completes at edge t0+2 (ack visible next cycle) and frees the arbiter at edge t0+3.
  int            edge_n = 0;
  bit            chk_en = 0;
  bit            m_active, m_sel, m_we, m_last;
  int            m_t0;
  logic [AW-1:0] m_adrs;
  logic [DW-1:0] m_wdata, m_rv;
  logic [DW-1:0] m_mem [256];
  bit            m_mem_v [256];
  int            m_cnt [2];
  logic [DW-1:0] m_rdata [2];
  bit            e_ack0, e_ack1, e_mem_en, e_busy;

  always @(posedge sys_clk) begin
    edge_n++;
    chk_en   = 1;
    e_ack0   = 0;
    e_ack1   = 0;
    e_mem_en = 0;
    if (m_active && edge_n == m_t0 + 1) begin
      if (m_we) begin
        m_mem[m_adrs]   = m_wdata;
        m_mem_v[m_adrs] = 1;
      end else begin
        m_rv = m_mem_v[m_adrs] ? m_mem[m_adrs] : dflt(m_adrs);
      end
    end
    if (!resetn) begin
      m_active   = 0;
      m_last     = 1;
      m_sel      = 0;
      m_we       = 0;
      m_adrs     = '0;
      m_wdata    = '0;
      m_cnt      = '{0, 0};
      m_rdata[0] = '0;
      m_rdata[1] = '0;
    end else begin
      if (m_active && edge_n == m_t0 + 2) begin
        if (!m_we) m_rdata[m_sel] = m_rv;
        if (m_cnt[m_sel] < CMAX) m_cnt[m_sel] = m_cnt[m_sel] + 1;
        m_last = m_sel;
        if (m_sel) e_ack1 = 1;
        else       e_ack0 = 1;
      end
      if (!m_active && (bus.req0 || bus.req1)) begin
        m_sel    = (bus.req0 && bus.req1) ? !m_last : bus.req1;
        m_we     = m_sel ? bus.we1    : bus.we0;
        m_adrs   = m_sel ? bus.adrs1  : bus.adrs0;
        m_wdata  = m_sel ? bus.wdata1 : bus.wdata0;
        m_active = 1;
        m_t0     = edge_n;
        e_mem_en = 1;
      end else if (m_active && edge_n == m_t0 + 3) begin
        m_active = 0;
      end
    end
    e_busy = m_active;
  end

  always @(negedge sys_clk) begin
    if (chk_en) begin
      check_eq("ack0",      32'(bus.ack0),      32'(e_ack0));
      check_eq("ack1",      32'(bus.ack1),      32'(e_ack1));
      check_eq("mem_en",    32'(bus.mem_en),    32'(e_mem_en));
      check_eq("mem_we",    32'(bus.mem_we),    32'(m_we));
      check_eq("mem_adrs",  32'(bus.mem_adrs),  32'(m_adrs));
      check_eq("mem_wdata", bus.mem_wdata,      m_wdata);
      check_eq("busy",      32'(bus.busy),      32'(e_busy));
      check_eq("rdata0",    bus.rdata0,         m_rdata[0]);
      check_eq("rdata1",    bus.rdata1,         m_rdata[1]);
      check_eq("cnt0",      32'(bus.cnt0),      32'(m_cnt[0]));
      check_eq("cnt1",      32'(bus.cnt1),      32'(m_cnt[1]));
    end
  end

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 resetn = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic do_txn(input int core, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output logic [DW-1:0] rd, output int t_raise, output int t_ack);
    bit got;
    got   = 0;
    t_ack = -1;
    rd    = '0;
    if (core == 0) begin bus.we0 = we; bus.adrs0 = a; bus.wdata0 = d; bus.req0 = 1'b1; end
    else           begin bus.we1 = we; bus.adrs1 = a; bus.wdata1 = d; bus.req1 = 1'b1; end
    t_raise = edge_n;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge sys_clk);
      #1;
      if ((core == 0) ? bus.ack0 : bus.ack1) begin
        got   = 1;
        t_ack = edge_n;
        rd    = (core == 0) ? bus.rdata0 : bus.rdata1;
      end
    end
    if (core == 0) bus.req0 = 1'b0;
    else           bus.req1 = 1'b0;
    check_eq((core == 0) ? "txn0_ack_seen" : "txn1_ack_seen", 32'(got), 32'd1);
  endtask

  function automatic logic [AW-1:0] rand_adr();
    if ($urandom_range(0, 7) == 0) return 8'hFF;
    return 8'($urandom_range(0, 7));
  endfunction

  task automatic drive_core(input int core);
    bit req, ack;
    req = (core == 0) ? bus.req0 : bus.req1;
    ack = (core == 0) ? bus.ack0 : bus.ack1;
    if (req && (ack || $urandom_range(0, 49) == 0)) begin
      if (core == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
    end else if (!req && $urandom_range(0, 2) == 0) begin
      if (core == 0) begin
        bus.we0 = 1'($urandom_range(0, 1)); bus.adrs0 = rand_adr(); bus.wdata0 = $urandom; bus.req0 = 1'b1;
      end else begin
        bus.we1 = 1'($urandom_range(0, 1)); bus.adrs1 = rand_adr(); bus.wdata1 = $urandom; bus.req1 = 1'b1;
      end
    end else if (req && $urandom_range(0, 7) == 0) begin
      // Field churn while waiting or in flight: only the value present at the grant edge counts.
      if (core == 0) bus.wdata0 = $urandom; else bus.wdata1 = $urandom;
    end
  endtask

  initial begin
    logic [DW-1:0] rd0, rd1;
    int tr0, tr1, ta0, ta1, nack, prev, k;
    bit seen;

    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.adrs0 = '0; bus.adrs1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    bus_s.req0 = 1'b0; bus_s.req1 = 1'b0;
    bus_s.we0 = 1'b0; bus_s.we1 = 1'b0;
    bus_s.adrs0 = '0; bus_s.adrs1 = '0;
    bus_s.wdata0 = '0; bus_s.wdata1 = '0;

    // Reset held 3 cycles with both requests high.
    repeat (3) @(posedge sys_clk);
    #1;
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check_eq("rst_cnt0", 32'(bus.cnt0), 32'd0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    resetn = 1'b1;
    idle(2);

    // Single load of a word placed by core 1.
    do_txn(1, 1'b1, 8'h10, 32'hDEADBEEF, rd1, tr1, ta1);
    idle(2);
    do_txn(0, 1'b0, 8'h10, 32'h0, rd0, tr0, ta0);
    check_eq("load_latency", 32'(ta0 - tr0), 32'd3);
    check_eq("load_rdata0", rd0, 32'hDEADBEEF);
    check_eq("load_rdata1_kept", bus.rdata1, 32'h0);
    check_eq("load_cnt0", 32'(bus.cnt0), 32'd1);
    idle(2);

    // Simultaneous requests after reset: core 0 first, core 1 reads its store.
    do_reset();
    idle(1);
    fork
      do_txn(0, 1'b1, 8'h20, 32'h11111111, rd0, tr0, ta0);
      do_txn(1, 1'b0, 8'h20, 32'h0, rd1, tr1, ta1);
    join
    check_eq("sim_ack0_time", 32'(ta0 - tr0), 32'd3);
    check_eq("sim_ack1_time", 32'(ta1 - tr1), 32'd7);
    check_eq("sim_rdata1", rd1, 32'h11111111);
    idle(2);

    // Round-robin with both cores requesting continuously.
    do_reset();
    bus.we0 = 1'b1; bus.adrs0 = 8'h30; bus.wdata0 = 32'hA5A5_0001;
    bus.we1 = 1'b0; bus.adrs1 = 8'h30;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    nack = 0;
    prev = -1;
    for (int c = 0; c < 60 && nack < 10; c++) begin
      @(posedge sys_clk);
      #1;
      if (bus.ack0 || bus.ack1) begin
        check_eq("rr_core", 32'(bus.ack1), 32'(nack % 2));
        if (prev >= 0) check_eq("rr_spacing", 32'(edge_n - prev), 32'd4);
        prev = edge_n;
        nack++;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    check_eq("rr_acks", 32'(nack), 32'd10);
    check_eq("rr_cnt0", 32'(bus.cnt0), 32'd5);
    check_eq("rr_cnt1", 32'(bus.cnt1), 32'd5);
    idle(3);

    // Reset asserted during the WAIT cycle of a core-1 load.
    bus.we1 = 1'b0; bus.adrs1 = 8'h20; bus.req1 = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge sys_clk);
      #1;
      if (bus.mem_en) seen = 1;
    end
    check_eq("mid_mem_en_seen", 32'(seen), 32'd1);
    @(posedge sys_clk);
    #1 resetn = 1'b0;
    @(posedge sys_clk);
    #1;
    check_eq("mid_ack1", 32'(bus.ack1), 32'd0);
    check_eq("mid_rdata1", bus.rdata1, 32'h0);
    check_eq("mid_cnt1", 32'(bus.cnt1), 32'd0);
    check_eq("mid_busy", 32'(bus.busy), 32'd0);
    @(posedge sys_clk);
    #1;
    check_eq("mid_mem_en_off", 32'(bus.mem_en), 32'd0);
    resetn = 1'b1;
    do_txn(1, 1'b0, 8'h20, 32'h0, rd1, tr1, ta1);
    check_eq("mid_reissue_rdata1", rd1, 32'h11111111);
    idle(2);

    // Random traffic with occasional single-cycle resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge sys_clk);
      #1;
      if (!resetn) resetn = 1'b1;
      else if ($urandom_range(0, 299) == 0) resetn = 1'b0;
      drive_core(0);
      drive_core(1);
    end
    resetn = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    idle(6);

    // CNT_W = 2 instance: back-to-back core-0 stores to the top address.
    bus_s.we0 = 1'b1; bus_s.adrs0 = 8'hFF; bus_s.wdata0 = 32'h0000_00A5; bus_s.req0 = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 5; c++) begin
      @(posedge sys_clk);
      #1;
      if (bus_s.mem_en) begin
        check_eq("sat_mem_adrs", 32'(bus_s.mem_adrs), 32'hFF);
        check_eq("sat_mem_we", 32'(bus_s.mem_we), 32'd1);
      end
      if (bus_s.ack0) begin
        k++;
        check_eq("sat_cnt0", 32'(bus_s.cnt0), 32'((k < 3) ? k : 3));
      end
    end
    bus_s.req0 = 1'b0;
    check_eq("sat_acks", 32'(k), 32'd5);
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
